// File: rtl/bsg_wait_cycles_array.sv
// bsg_wait_cycles_array: els_p independent, runtime-programmable wait timers.
// Each channel is armed by an activate pulse carrying its own cycle count N,
// holds ready_r_o low while counting, and pulses done_o on expiry. Channels
// can run one-shot or periodic (auto-reload), and can be cancelled or
// retriggered at any time.
module bsg_wait_cycles_array #(
  parameter int els_p        = 4,
  parameter int max_cycles_p = 255,
  parameter int width_p      = $clog2(max_cycles_p + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [els_p-1:0]         activate_i,
  input  logic [els_p*width_p-1:0] cycles_i,
  input  logic [els_p-1:0]         periodic_i,
  input  logic [els_p-1:0]         cancel_i,
  output logic [els_p-1:0]         ready_r_o,
  output logic [els_p-1:0]         done_o,
  output logic                     all_ready_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [width_p-1:0] one_c = width_p'(1);

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : ch
      state_e             state_reg, state_next;
      logic [width_p-1:0] count_reg, count_next;
      logic [width_p-1:0] len_reg, len_next;
      logic               periodic_reg, periodic_next;
      logic               ready_reg, ready_next;
      logic               done_reg, done_next;
      logic [width_p-1:0] n_in;

      assign n_in = cycles_i[gi*width_p +: width_p];

      // Channel state register; reset returns the channel to idle/ready.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg    <= S_IDLE;
          count_reg    <= '0;
          len_reg      <= '0;
          periodic_reg <= 1'b0;
          ready_reg    <= 1'b1;
          done_reg     <= 1'b0;
        end else begin
          state_reg    <= state_next;
          count_reg    <= count_next;
          len_reg      <= len_next;
          periodic_reg <= periodic_next;
          ready_reg    <= ready_next;
          done_reg     <= done_next;
        end
      end

      // Next-state logic: cancel beats activate, activate (retrigger) beats
      // expiry, so an aborted or overridden wait never emits a done pulse.
      always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        len_next      = len_reg;
        periodic_next = periodic_reg;
        ready_next    = ready_reg;
        done_next     = 1'b0;
        if (cancel_i[gi]) begin
          state_next = S_IDLE;
          count_next = '0;
          ready_next = 1'b1;
        end else if (activate_i[gi]) begin
          if (n_in != '0) begin
            state_next    = S_WAIT;
            count_next    = n_in;
            len_next      = n_in;
            periodic_next = periodic_i[gi];
            ready_next    = 1'b0;
          end else begin
            // Zero-length wait completes immediately; periodic N=0 is a no-op.
            state_next = S_IDLE;
            count_next = '0;
            ready_next = 1'b1;
            done_next  = ~periodic_i[gi];
          end
        end else if (state_reg == S_WAIT) begin
          if (count_reg == one_c) begin
            done_next = 1'b1;
            if (periodic_reg) begin
              count_next = len_reg;
            end else begin
              state_next = S_IDLE;
              count_next = '0;
              ready_next = 1'b1;
            end
          end else begin
            count_next = count_reg - one_c;
          end
        end
      end

      // A waiting channel always holds a nonzero count.
      assert property (@(posedge clk) disable iff (reset)
                       (state_reg == S_WAIT) |-> (count_reg != '0));

      assign ready_r_o[gi] = ready_reg;
      assign done_o[gi]    = done_reg;
    end
  endgenerate

  assign all_ready_o = &ready_r_o;

endmodule

// File: tb/tb_bsg_wait_cycles_array.sv
// Directed testbench for bsg_wait_cycles_array (4 channels, 8-bit counts).
module tb_bsg_wait_cycles_array;

  localparam int els_c = 4;
  localparam int w_c   = 8;

  logic               clk;
  logic               reset;
  logic [els_c-1:0]   activate;
  logic [els_c*w_c-1:0] cycles;
  logic [els_c-1:0]   periodic;
  logic [els_c-1:0]   cancel;
  logic [els_c-1:0]   ready_r;
  logic [els_c-1:0]   done;
  logic               all_ready;

  int vec_count = 0;
  int err_count = 0;

  bsg_wait_cycles_array #(.els_p(4), .max_cycles_p(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .activate_i (activate),
    .cycles_i   (cycles),
    .periodic_i (periodic),
    .cancel_i   (cancel),
    .ready_r_o  (ready_r),
    .done_o     (done),
    .all_ready_o(all_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then observed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    activate = '0;
    cycles   = '0;
    periodic = '0;
    cancel   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      vec_count++;
      if (ready_r !== 4'b1111 || done !== 4'b0000 || all_ready !== 1'b1) begin
        $display("FAIL reset cyc%0d: ready=%b done=%b all=%b, want 1111 0000 1", k, ready_r, done, all_ready);
        err_count++;
      end
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vec_count++;
      if (ready_r !== 4'b1111 || done !== 4'b0000 || all_ready !== 1'b1) begin
        $display("FAIL idle cyc%0d: ready=%b done=%b all=%b, want 1111 0000 1", k, ready_r, done, all_ready);
        err_count++;
      end
    end
  endtask

  task automatic test_oneshot(input int n);
    idle_inputs();
    activate[0] = 1'b1;
    cycles[0 +: w_c] = w_c'(n);
    step();
    idle_inputs();
    for (int k = 0; k < n; k++) begin
      vec_count++;
      if (ready_r !== 4'b1110 || done !== 4'b0000 || all_ready !== 1'b0) begin
        $display("FAIL oneshot N=%0d wait%0d: ready=%b done=%b all=%b, want 1110 0000 0", n, k, ready_r, done, all_ready);
        err_count++;
      end
      step();
    end
    vec_count++;
    if (ready_r !== 4'b1111 || done !== 4'b0001 || all_ready !== 1'b1) begin
      $display("FAIL oneshot N=%0d expiry: ready=%b done=%b all=%b, want 1111 0001 1", n, ready_r, done, all_ready);
      err_count++;
    end
    step();
    vec_count++;
    if (ready_r !== 4'b1111 || done !== 4'b0000) begin
      $display("FAIL oneshot N=%0d after: ready=%b done=%b, want 1111 0000", n, ready_r, done);
      err_count++;
    end
  endtask

  task automatic test_zero();
    idle_inputs();
    activate[1] = 1'b1;
    step();
    idle_inputs();
    vec_count++;
    if (ready_r !== 4'b1111 || done !== 4'b0010) begin
      $display("FAIL zero oneshot pulse: ready=%b done=%b, want 1111 0010", ready_r, done);
      err_count++;
    end
    step();
    vec_count++;
    if (ready_r !== 4'b1111 || done !== 4'b0000) begin
      $display("FAIL zero oneshot after: ready=%b done=%b, want 1111 0000", ready_r, done);
      err_count++;
    end
    activate[1] = 1'b1;
    periodic[1] = 1'b1;
    step();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      vec_count++;
      if (ready_r !== 4'b1111 || done !== 4'b0000) begin
        $display("FAIL zero periodic cyc%0d: ready=%b done=%b, want 1111 0000", k, ready_r, done);
        err_count++;
      end
      step();
    end
  endtask

  task automatic test_periodic();
    logic [3:0] exp_done;
    idle_inputs();
    activate[2] = 1'b1;
    periodic[2] = 1'b1;
    cycles[2*w_c +: w_c] = 8'd4;
    step();
    idle_inputs();
    for (int c = 1; c <= 20; c++) begin
      step();
      exp_done = (c % 4 == 0) ? 4'b0100 : 4'b0000;
      vec_count++;
      if (ready_r !== 4'b1011 || done !== exp_done) begin
        $display("FAIL periodic cyc%0d: ready=%b done=%b, want 1011 %b", c, ready_r, done, exp_done);
        err_count++;
      end
    end
    cancel[2] = 1'b1;
    step();
    idle_inputs();
    for (int k = 0; k < 6; k++) begin
      vec_count++;
      if (ready_r !== 4'b1111 || done !== 4'b0000) begin
        $display("FAIL periodic cancel cyc%0d: ready=%b done=%b, want 1111 0000", k, ready_r, done);
        err_count++;
      end
      step();
    end
  endtask

  // Arm ch3 with n1, retrigger with n2 on the edge k1 cycles later; expect
  // exactly one done pulse n2 edges after the retrigger edge.
  task automatic test_retrigger(input int n1, input int k1, input int n2);
    int total;
    logic [3:0] exp_ready;
    logic [3:0] exp_done;
    idle_inputs();
    activate[3] = 1'b1;
    cycles[3*w_c +: w_c] = w_c'(n1);
    step();
    idle_inputs();
    for (int e = 1; e < k1; e++) step();
    activate[3] = 1'b1;
    cycles[3*w_c +: w_c] = w_c'(n2);
    total = k1 + n2 + 3;
    for (int e = k1; e <= total; e++) begin
      step();
      idle_inputs();
      exp_ready = (e >= k1 + n2) ? 4'b1111 : 4'b0111;
      exp_done  = (e == k1 + n2) ? 4'b1000 : 4'b0000;
      vec_count++;
      if (ready_r !== exp_ready || done !== exp_done) begin
        $display("FAIL retrigger %0d/%0d/%0d edge%0d: ready=%b done=%b, want %b %b",
                 n1, k1, n2, e, ready_r, done, exp_ready, exp_done);
        err_count++;
      end
    end
  endtask

  task automatic test_multi();
    logic [3:0] exp_ready [0:5];
    logic [3:0] exp_done  [0:5];
    exp_ready[0] = 4'b0000; exp_done[0] = 4'b0000;
    exp_ready[1] = 4'b0010; exp_done[1] = 4'b0000;
    exp_ready[2] = 4'b0011; exp_done[2] = 4'b0001;
    exp_ready[3] = 4'b0011; exp_done[3] = 4'b0000;
    exp_ready[4] = 4'b0011; exp_done[4] = 4'b0000;
    exp_ready[5] = 4'b0111; exp_done[5] = 4'b0100;
    idle_inputs();
    activate = 4'b1111;
    cycles   = {8'd7, 8'd5, 8'd3, 8'd2};
    for (int e = 0; e <= 5; e++) begin
      step();
      idle_inputs();
      if (e == 0) begin
        cancel[1]   = 1'b1;
        activate[1] = 1'b1;
        cycles[1*w_c +: w_c] = 8'd4;
      end
      vec_count++;
      if (ready_r !== exp_ready[e] || done !== exp_done[e] || all_ready !== (&exp_ready[e])) begin
        $display("FAIL multi edge%0d: ready=%b done=%b all=%b, want %b %b %b",
                 e, ready_r, done, all_ready, exp_ready[e], exp_done[e], &exp_ready[e]);
        err_count++;
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec_count++;
      if (ready_r !== 4'b1111 || done !== 4'b0000 || all_ready !== 1'b1) begin
        $display("FAIL multi reset cyc%0d: ready=%b done=%b all=%b, want 1111 0000 1", k, ready_r, done, all_ready);
        err_count++;
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    for (int n = 1; n <= 8; n++) test_oneshot(n);
    test_oneshot(255);
    test_zero();
    test_periodic();
    test_retrigger(5, 3, 2);
    test_retrigger(5, 2, 2);
    test_retrigger(3, 3, 2);
    test_multi();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/bsg_wait_cycles_array.md
Name: bsg_wait_cycles_array

Overview:
- Multi-channel, runtime-programmable generalisation of the single fixed-count wait timer.
- Each of els_p independent channels is armed by an activate pulse with its own cycle count.
- ready_r_o is held low until that count has elapsed, and done_o pulses on completion.
- Adds a periodic (auto-reload) mode, cancel, and retrigger.
- Used for reset sequencing, PHY settle delays and periodic housekeeping ticks across several subsystems with one shared block.

Parameters:
- els_p, 4, number of independent channels (>=1).
- max_cycles_p, 255, largest programmable wait count (>=1).
- width_p, $clog2(max_cycles_p+1), counter and count-input width (derived; do not override).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- activate_i  input  els_p  per-channel start pulse; sampled each posedge.
- cycles_i  input  els_p*width_p  per-channel wait count N; channel i at bits [i*width_p +: width_p]; sampled only when activate_i[i]=1.
- periodic_i  input  els_p  per-channel mode, sampled with activate_i: 0 = one-shot, 1 = periodic.
- cancel_i  input  els_p  per-channel abort.
- ready_r_o  output  els_p  registered; 1 = idle/expired, 0 = waiting.
- done_o  output  els_p  registered one-cycle completion pulse.
- all_ready_o  output  1  AND-reduction of ready_r_o (combinational from registers).

Behaviour:
- Reset: ready_r_o = all 1s, done_o = 0, all_ready_o = 1, counters = 0, channels IDLE. reset overrides every other input.
- Per-channel FSM states: IDLE, WAIT. No cross-channel interaction.
- IDLE, activate_i[i]=1, N>0:
  - Load counter = N, latch N and the mode, go to WAIT.
  - ready_r_o[i] = 0 from the next cycle.
- IDLE, activate_i[i]=1, N=0:
  - Stay IDLE; ready_r_o[i] stays 1.
  - done_o[i] pulses 1 the next cycle, in one-shot mode only.
  - Periodic with N=0 is ignored: no pulse, stays IDLE.
- WAIT, every cycle: counter decrements by 1.
- Expiry, i.e. counter==1 at the edge, occurring N edges after the activate edge:
  - One-shot: go to IDLE; ready_r_o[i]=1 and done_o[i]=1 in the same cycle; done_o[i]=0 the cycle after.
  - Periodic: reload counter = latched N and stay in WAIT; ready_r_o[i] stays 0; done_o[i]=1 for one cycle every N cycles.
- Timing example: activate at edge E0 with N=3 gives ready_r_o low after E0, E1, E2, and high after E3.
- Retrigger: activate_i[i]=1 while in WAIT (including the expiry cycle) restarts with the new N and mode. No done pulse for the aborted wait. Expiry coinciding with retrigger produces no done pulse.
- Cancel:
  - cancel_i[i]=1 forces IDLE: ready_r_o[i]=1 next cycle, done_o[i]=0, counter cleared.
  - Cancel beats a simultaneous activate and a simultaneous expiry, so no done pulse is emitted.
  - cancel_i in IDLE has no effect.
- Counter arithmetic is unsigned width_p bits. N is always <= max_cycles_p by construction; a counter value of 0 in WAIT is unreachable (assert in simulation).
- All outputs are registered except all_ready_o. There is no combinational path from any input to any output.
- Reset asserted mid-WAIT returns the channel to the reset state on the next edge with no done pulse.

Test Plan:
- Reset held 5 cycles, then idle → ready_r_o=4'b1111, done_o=0, all_ready_o=1 throughout.
- Ch0 activate pulse, N=3, one-shot:
  - ready_r_o[0]=0 for exactly 3 cycles, then 1; done_o[0]=1 in the single cycle ready rises.
  - all_ready_o low for those 3 cycles.
  - Sweep N=1..8 and N=max_cycles_p.
- Ch1 N=0 one-shot → ready_r_o[1] never drops, done_o[1]=1 one cycle after activate. Ch1 N=0 periodic → no output change.
- Ch2 periodic N=4 for 20 cycles → done_o[2] pulses at cycles 4, 8, 12, 16, 20 after activate; ready_r_o[2]=0 until cancel_i[2] pulse, then 1 the next cycle with no further done.
- Ch3 N=5, re-activate after 3 cycles with N=2 → ready rises 2 cycles after the second activate, exactly one done pulse. Repeat with the retrigger on the expiry cycle → no done that cycle.
- All channels active with distinct N (2, 3, 5, 7); assert cancel and activate together on ch1; assert reset mid-wait → independent expiry timing per channel, ch1 cancelled, and all outputs at reset values one cycle after reset.
